// File: rtl/uart_cmd_parser.sv
// Byte-level parser for "I <mode> <A hex><op><B hex>=" frames from the UART receiver.
// Holds the decoded command on a valid/ready handshake toward the ALU.
module uart_cmd_parser #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         cmd_ready,
  output logic         cmd_valid,
  output logic         cmd_signed,
  output logic [1:0]   cmd_op,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         err,
  output logic         overrun
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] LastDig = CntW'(DIGITS - 1);

  localparam logic [7:0] ChI     = 8'h49;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChS     = 8'h53;
  localparam logic [7:0] ChU     = 8'h55;
  localparam logic [7:0] ChEq    = 8'h3D;

  typedef enum logic [3:0] {
    StIdle, StSp1, StMode, StSp2, StADig, StOp, StBDig, StEq, StHold
  } state_e;

  state_e          state_q, state_d;
  logic            signed_q, signed_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            overrun_q, overrun_d;

  logic            dig_ok;
  logic [3:0]      nib;
  logic            bad;

  // Returns {is_hex, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [7:0] v;
    if (c >= 8'h30 && c <= 8'h39) begin
      v = c - 8'h30;
      return {1'b1, v[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      v = c - 8'h57;
      return {1'b1, v[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      v = c - 8'h37;
      return {1'b1, v[3:0]};
    end
    return 5'd0;
  endfunction

  always_comb begin
    state_d   = state_q;
    signed_d  = signed_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    overrun_d = 1'b0;
    bad       = 1'b0;
    {dig_ok, nib} = hex_nib(rx_data);

    if (state_q == StHold) begin
      // Bytes arriving while the command is held are dropped, never parsed.
      overrun_d = rx_valid;
      if (cmd_ready) state_d = StIdle;
    end else if (rx_valid) begin
      case (state_q)
        StIdle: begin
          if (rx_data == ChI) state_d = StSp1;
          else if (rx_data != ChCr && rx_data != ChLf) err_d = 1'b1;
        end
        StSp1: begin
          if (rx_data == ChSpace) state_d = StMode;
          else bad = 1'b1;
        end
        StMode: begin
          if (rx_data == ChS || rx_data == ChU) begin
            signed_d = (rx_data == ChS);
            state_d  = StSp2;
          end else begin
            bad = 1'b1;
          end
        end
        StSp2: begin
          if (rx_data == ChSpace) begin
            a_d     = '0;
            cnt_d   = '0;
            state_d = StADig;
          end else begin
            bad = 1'b1;
          end
        end
        StADig: begin
          if (dig_ok) begin
            a_d   = {a_q[W-5:0], nib};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastDig) state_d = StOp;
          end else begin
            bad = 1'b1;
          end
        end
        StOp: begin
          b_d     = '0;
          cnt_d   = '0;
          state_d = StBDig;
          case (rx_data)
            8'h2B:   op_d = 2'b00;
            8'h2D:   op_d = 2'b01;
            8'h2A:   op_d = 2'b10;
            8'h2F:   op_d = 2'b11;
            default: begin
              bad     = 1'b1;
              b_d     = b_q;
              cnt_d   = cnt_q;
              state_d = state_q;
            end
          endcase
        end
        StBDig: begin
          if (dig_ok) begin
            b_d   = {b_q[W-5:0], nib};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastDig) state_d = StEq;
          end else begin
            bad = 1'b1;
          end
        end
        StEq: begin
          if (rx_data == ChEq) state_d = StHold;
          else bad = 1'b1;
        end
        default: state_d = StIdle;
      endcase

      // An unexpected 'I' is taken as the start of a new frame.
      if (bad) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = (rx_data == ChI) ? StSp1 : StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      signed_q  <= 1'b0;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      signed_q  <= signed_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd_valid  = (state_q == StHold);
  assign cmd_signed = signed_q;
  assign cmd_op     = op_q;
  assign op_a       = a_q;
  assign op_b       = b_q;
  assign err        = err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frame streams checked every cycle against a position-based
// frame matcher that decodes fields arithmetically once a complete frame is buffered.
module tb_uart_cmd_parser;

  localparam int D    = 4;
  localparam int W    = 16;
  localparam int FLEN = 6 + 2 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         cmd_ready;
  logic         cmd_valid;
  logic         cmd_signed;
  logic [1:0]   cmd_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         err;
  logic         overrun;

  uart_cmd_parser #(.DIGITS(D), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_signed (cmd_signed),
    .cmd_op     (cmd_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .err        (err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: bytes of the frame matched so far, plus the last decoded command.
  logic [7:0]   m_buf[$];
  logic [7:0]   fq[$];
  logic         m_hold;
  logic         m_sign;
  logic [1:0]   m_op;
  logic [W-1:0] m_a, m_b;
  logic         exp_err, exp_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic bit is_opc(input logic [7:0] c);
    return c == "+" || c == "-" || c == "*" || c == "/";
  endfunction

  function automatic bit pos_ok(input int p, input logic [7:0] c);
    if (p == 1 || p == 3) return c == " ";
    if (p == 2) return c == "S" || c == "U";
    if (p == 4 + D) return is_opc(c);
    if (p == FLEN - 1) return c == "=";
    return hex_val(c) >= 0;
  endfunction

  function automatic void decode_frame();
    logic [7:0] oc;
    m_sign = (m_buf[2] == "S");
    oc = m_buf[4 + D];
    m_op = (oc == "+") ? 2'd0 : (oc == "-") ? 2'd1 : (oc == "*") ? 2'd2 : 2'd3;
    m_a = '0;
    m_b = '0;
    for (int i = 0; i < D; i++) begin
      m_a = W'(m_a * 16 + W'(hex_val(m_buf[4 + i])));
      m_b = W'(m_b * 16 + W'(hex_val(m_buf[5 + D + i])));
    end
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] c, input logic rdy);
    int p;
    exp_err = 1'b0;
    exp_ovr = 1'b0;
    if (m_hold) begin
      exp_ovr = v;
      if (rdy) m_hold = 1'b0;
    end else if (v) begin
      p = m_buf.size();
      if (p == 0) begin
        if (c == "I") m_buf.push_back(c);
        else if (c != 8'h0D && c != 8'h0A) exp_err = 1'b1;
      end else if (pos_ok(p, c)) begin
        m_buf.push_back(c);
        if (p == FLEN - 1) begin
          decode_frame();
          m_hold = 1'b1;
          m_buf.delete();
        end
      end else begin
        exp_err = 1'b1;
        m_buf.delete();
        if (c == "I") m_buf.push_back(c);
      end
    end
  endfunction

  task automatic cycle(input logic v, input logic [7:0] c, input logic rdy);
    rx_valid  = v;
    rx_data   = c;
    cmd_ready = rdy;
    model_step(v, c, rdy);
    @(posedge clk);
    #1;
    check("cmd_valid", 32'(cmd_valid), 32'(m_hold));
    check("err", 32'(err), 32'(exp_err));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    if (m_hold) begin
      check("cmd_signed", 32'(cmd_signed), 32'(m_sign));
      check("cmd_op", 32'(cmd_op), 32'(m_op));
      check("op_a", 32'(op_a), 32'(m_a));
      check("op_b", 32'(op_b), 32'(m_b));
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_buf.delete();
    m_hold = 1'b0;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_signed", 32'(cmd_signed), 32'd0);
    check("rst_cmd_op", 32'(cmd_op), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
  endtask

  task automatic send_str(input string s, input logic rdy);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic drain();
    int k = 0;
    while (m_hold && k < 40) begin
      cycle(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
      k++;
    end
    if (m_hold) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    string hexs;
    string ops;
    hexs = "0123456789abcdefABCDEF";
    ops  = "+-*/";
    m_hold = 1'b0;
    do_reset();

    send_str("I S fff5+fff7=", 1'b1);
    idle(2, 1'b1);
    check("t1_sign", 32'(cmd_signed), 32'd1);
    check("t1_a", 32'(op_a), 32'hFFF5);
    check("t1_b", 32'(op_b), 32'hFFF7);

    send_str("I U ABCD/0004=", 1'b0);
    idle(20, 1'b0);
    check("t2_valid_held", 32'(cmd_valid), 32'd1);
    check("t2_op", 32'(cmd_op), 32'd3);
    idle(1, 1'b1);
    idle(1, 1'b0);

    send_str("I S 12G4", 1'b0);
    send_str("I S 0001-0002=", 1'b0);
    check("t3_op", 32'(cmd_op), 32'd1);
    idle(1, 1'b1);

    send_str("I SI U 0010*0003=", 1'b0);
    check("t4_a", 32'(op_a), 32'h0010);
    send_str("x", 1'b0);
    send_str("y", 1'b1);
    send_str("\r\n\r", 1'b0);

    send_str("I S ff", 1'b0);
    do_reset();
    send_str("I U 1234+5678=", 1'b0);
    check("t6_a", 32'(op_a), 32'h1234);
    check("t6_b", 32'(op_b), 32'h5678);
    drain();

    for (int f = 0; f < 80; f++) begin
      fq.delete();
      fq.push_back("I");
      fq.push_back(" ");
      fq.push_back(($urandom_range(0, 1) == 1) ? 8'h53 : 8'h55);
      fq.push_back(" ");
      for (int i = 0; i < D; i++) fq.push_back(hexs[$urandom_range(0, 21)]);
      fq.push_back(ops[$urandom_range(0, 3)]);
      for (int i = 0; i < D; i++) fq.push_back(hexs[$urandom_range(0, 21)]);
      fq.push_back("=");
      if ($urandom_range(0, 4) == 0)
        fq[$urandom_range(0, FLEN - 1)] = 8'($urandom_range(8'h20, 8'h7E));
      if ($urandom_range(0, 3) == 0) fq.push_front(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      foreach (fq[i]) begin
        cycle(1'b1, fq[i], ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 3) == 0) idle(1, 1'b0);
      end
      if (m_hold && $urandom_range(0, 1) == 1)
        cycle(1'b1, 8'($urandom_range(8'h20, 8'h7E)), ($urandom_range(0, 1) == 1));
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
